piso_serializer: RTL

- Parallel-in/serial-out stage that sits downstream of the 4-bit parallel register.
- Accepts the register's parallel word through a valid/ready handshake and buffers one word in a holding register.
- Shifts each word out one bit per cycle, with downstream backpressure.
- Words stream back-to-back with no idle bit between them while upstream keeps supplying.

---
 rtl/piso_serializer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// PisoSerializer (module piso_serializer)
//
// Parallel-in / serial-out stage. A word is taken from upstream through a
// valid/ready handshake into a one-word holding register. It then moves into
// a shift register and is sent one bit per cycle under downstream
// backpressure. When the holding register is full as the last bit of a word
// is consumed, the next word reloads on the same edge, so consecutive words
// stream with no idle bit between them.
//
// Parameters
//   WIDTH      word width in bits (minimum 2)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = reset asserted)
//   in_valid   upstream word valid
//   in_ready   a word can be accepted this cycle (holding register empty)
//   pi         parallel word
//   so         serial data bit
//   so_valid   so carries a valid bit
//   so_ready   downstream consumes so this cycle
//   so_last    current bit is the last bit of its word
//   busy       a word is held or being shifted
//   word_cnt   count of fully transmitted words, wraps 255 -> 0
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pi,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  // SHIFT means the shifter holds a word whose bits are being presented.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_holdFull;
  logic [7:0]       r_wordCnt;

  logic w_accept;
  logic w_advance;
  logic w_lastDone;
  logic w_load;

  // Moves the shifter one position toward the output end with zero fill.
  function automatic logic [WIDTH-1:0] shiftOut(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  // Words only ever enter the holding register; the shifter is fed from it,
  // either from IDLE or on the edge that consumes the last bit of a word.
  assign w_accept   = in_valid & ~r_holdFull;
  assign w_advance  = (r_state == SHIFT) & so_ready;
  assign w_lastDone = w_advance & (r_cnt == LAST_IDX);
  assign w_load     = r_holdFull & ((r_state == IDLE) | w_lastDone);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_hold     <= '0;
      r_cnt      <= '0;
      r_holdFull <= 1'b0;
      r_wordCnt  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_hold <= pi;
      end

      if (w_load) begin
        r_shift <= r_hold;
        r_cnt   <= '0;
        r_state <= SHIFT;
      end else if (w_advance) begin
        r_shift <= shiftOut(r_shift);
        r_cnt   <= r_cnt + 1'b1;
        if (w_lastDone) begin
          r_state <= IDLE;
        end
      end

      if (w_lastDone) begin
        r_wordCnt <= r_wordCnt + 8'd1;
      end

      // Load needs a full holding register and accept needs an empty one,
      // so the two can never happen on the same edge.
      if (w_load) begin
        r_holdFull <= 1'b0;
      end else if (w_accept) begin
        r_holdFull <= 1'b1;
      end
    end
  end

  assign in_ready = ~r_holdFull;
  assign so_valid = (r_state == SHIFT);
  assign so       = so_valid & (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
  assign so_last  = so_valid & (r_cnt == LAST_IDX);
  assign busy     = so_valid | r_holdFull;
  assign word_cnt = r_wordCnt;

endmodule
